// File: rtl/mux_pipe_tree_if.sv
// Stream bundle for mux_pipe_tree: a wide multi-channel input side and a single-channel output side.
// The master drives the inputs and consumes the outputs. The slave is the mux tree itself.
interface mux_pipe_tree_if #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 16
);
    localparam int SELW = $clog2(NUM_IN);

    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SELW-1:0]         in_sel;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SELW-1:0]         out_sel;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_pipe_tree.sv
// Pipelined 4:1 mux tree. There is one register stage per tree level.
// A single global advance signal moves the whole pipeline forward, or holds all of it.
module mux_pipe_tree #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    mux_pipe_tree_if.slave bus
);
    localparam int SELW   = $clog2(NUM_IN);
    localparam int LEVELS = SELW / 2;

    // Each level's partial results live in one flat vector. Level 0 sits at the bottom.
    // This function returns the bit offset where level lvl starts.
    function automatic int level_off(input int lvl);
        int off;
        off = 0;
        for (int i = 0; i < lvl; i++) begin
            off += (NUM_IN >> (2 * (i + 1))) * WIDTH;
        end
        return off;
    endfunction

    localparam int TOT_BITS = level_off(LEVELS);

    logic                        adv;
    logic [TOT_BITS-1:0]         data_reg;
    logic [TOT_BITS-1:0]         data_next;
    logic [LEVELS-1:0]           valid_reg;
    logic [LEVELS-1:0]           valid_next;
    logic [LEVELS-1:0][SELW-1:0] sel_reg;
    logic [LEVELS-1:0][SELW-1:0] sel_next;

    assign adv = !valid_reg[LEVELS-1] || bus.out_ready;

    genvar gi, mi;
    generate
        for (gi = 0; gi < LEVELS; gi++) begin : g_level
            localparam int N_OUT = NUM_IN >> (2 * (gi + 1));
            localparam int OFF   = level_off(gi);

            logic [4*N_OUT*WIDTH-1:0] src_data;
            logic [1:0]               src_sel;

            if (gi == 0) begin : g_first
                assign src_data      = bus.in_data;
                assign src_sel       = bus.in_sel[1:0];
                assign valid_next[0] = bus.in_valid;
                assign sel_next[0]   = bus.in_sel;
            end else begin : g_rest
                localparam int PREV = level_off(gi - 1);
                // Steer this level with the select copy that travelled alongside the previous stage.
                assign src_data       = data_reg[PREV +: 4*N_OUT*WIDTH];
                assign src_sel        = sel_reg[gi-1][2*gi+1 -: 2];
                assign valid_next[gi] = valid_reg[gi-1];
                assign sel_next[gi]   = sel_reg[gi-1];
            end

            for (mi = 0; mi < N_OUT; mi++) begin : g_mux
                logic [4*WIDTH-1:0] quad;
                logic [WIDTH-1:0]   pick;

                assign quad = src_data[mi*4*WIDTH +: 4*WIDTH];

                always_comb begin
                    pick = quad[0 +: WIDTH];
                    case (src_sel)
                        2'd0: pick = quad[0*WIDTH +: WIDTH];
                        2'd1: pick = quad[1*WIDTH +: WIDTH];
                        2'd2: pick = quad[2*WIDTH +: WIDTH];
                        2'd3: pick = quad[3*WIDTH +: WIDTH];
                        default: pick = quad[0 +: WIDTH];
                    endcase
                end

                assign data_next[OFF + mi*WIDTH +: WIDTH] = pick;
            end
        end
    endgenerate

    // Bubbles still load don't-care data. Only the valid bits decide what reaches the output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg  <= '0;
            valid_reg <= '0;
            sel_reg   <= '0;
        end else if (adv) begin
            data_reg  <= data_next;
            valid_reg <= valid_next;
            sel_reg   <= sel_next;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = valid_reg[LEVELS-1];
    assign bus.out_data  = data_reg[TOT_BITS-WIDTH +: WIDTH];
    assign bus.out_sel   = sel_reg[LEVELS-1];
endmodule

// File: tb/tb_mux_pipe_tree.sv
// Directed bench for mux_pipe_tree. It drives a 64x16 instance through the main scenarios.
// It also runs 8x4 and 32x64 instances against a small scoreboard.
module tb_mux_pipe_tree;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mux_pipe_tree_if #(.WIDTH(64), .NUM_IN(16)) bus_m ();
    mux_pipe_tree_if #(.WIDTH(8),  .NUM_IN(4))  bus_s ();
    mux_pipe_tree_if #(.WIDTH(32), .NUM_IN(64)) bus_b ();

    mux_pipe_tree #(.WIDTH(64), .NUM_IN(16)) u_dut   (.clk(clk), .reset_n(reset_n), .bus(bus_m));
    mux_pipe_tree #(.WIDTH(8),  .NUM_IN(4))  u_small (.clk(clk), .reset_n(reset_n), .bus(bus_s));
    mux_pipe_tree #(.WIDTH(32), .NUM_IN(64)) u_big   (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  qs_data[$];
    logic [1:0]  qs_sel[$];
    logic [31:0] qb_data[$];
    logic [5:0]  qb_sel[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] chan(input int k);
        return 64'h1111_0000_0000_0000 * 64'(k) + 64'(k);
    endfunction

    task automatic drive(input logic v, input int sel);
        bus_m.in_valid = v;
        bus_m.in_sel   = 4'(sel);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int k);
        check({tag, "_valid"}, 64'(bus_m.out_valid), 64'd1);
        check({tag, "_data"},  bus_m.out_data, chan(k));
        check({tag, "_sel"},   64'(bus_m.out_sel), 64'(k));
    endtask

    initial begin
        reset_n         = 1'b0;
        bus_m.in_valid  = 1'b0;
        bus_m.in_sel    = '0;
        bus_m.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) bus_m.in_data[k*64 +: 64] = chan(k);
        bus_s.in_valid  = 1'b0;
        bus_s.in_sel    = '0;
        bus_s.in_data   = '0;
        bus_s.out_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.in_sel    = '0;
        bus_b.in_data   = '0;
        bus_b.out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_out_valid", 64'(bus_m.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus_m.in_ready), 64'd1);
        check("rst_out_data",  bus_m.out_data, 64'd0);
        check("rst_out_sel",   64'(bus_m.out_sel), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;

        // Streaming: selects 0,5,10,15 back to back
        drive(1, 0);  tick();
        check("stream_lat1_valid", 64'(bus_m.out_valid), 64'd0);
        check("stream_in_ready",   64'(bus_m.in_ready), 64'd1);
        drive(1, 5);  tick(); expect_out("stream0", 0);
        drive(1, 10); tick(); expect_out("stream5", 5);
        drive(1, 15); tick(); expect_out("stream10", 10);
        drive(0, 0);  tick(); expect_out("stream15", 15);
        tick();
        check("stream_drained", 64'(bus_m.out_valid), 64'd0);

        // Backpressure: stall three cycles with a pending input
        drive(1, 1); tick();
        drive(1, 2); tick(); expect_out("bp_pre", 1);
        bus_m.out_ready = 1'b0;
        drive(1, 3);
        #1;
        check("bp_in_ready_low", 64'(bus_m.in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_out("bp_hold", 1);
            check("bp_stall_ready", 64'(bus_m.in_ready), 64'd0);
        end
        bus_m.out_ready = 1'b1;
        drive(1, 3); tick(); expect_out("bp_res2", 2);
        drive(1, 4); tick(); expect_out("bp_res3", 3);
        drive(0, 0); tick(); expect_out("bp_res4", 4);
        tick();
        check("bp_drained", 64'(bus_m.out_valid), 64'd0);

        // Bubbles: valid pattern 1,0,1
        drive(1, 6); tick();
        drive(0, 0); tick(); expect_out("bub_a", 6);
        drive(1, 9); tick();
        check("bub_gap", 64'(bus_m.out_valid), 64'd0);
        drive(0, 0); tick(); expect_out("bub_b", 9);
        tick();
        check("bub_end", 64'(bus_m.out_valid), 64'd0);

        // Mid-stream reset between clock edges
        drive(1, 3); tick();
        drive(1, 7); tick(); expect_out("mrst_pre", 3);
        drive(0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_valid", 64'(bus_m.out_valid), 64'd0);
        check("mrst_data",  bus_m.out_data, 64'd0);
        check("mrst_sel",   64'(bus_m.out_sel), 64'd0);
        check("mrst_ready", 64'(bus_m.in_ready), 64'd1);
        #2;
        reset_n = 1'b1;
        tick();
        check("mrst_post1", 64'(bus_m.out_valid), 64'd0);
        tick();
        check("mrst_post2", 64'(bus_m.out_valid), 64'd0);
        drive(1, 12); tick();
        check("mrst_first_lat", 64'(bus_m.out_valid), 64'd0);
        drive(0, 0);  tick(); expect_out("mrst_first", 12);
        tick();

        // Boundary select: top channel all-ones, all others zero
        bus_m.in_data = '0;
        bus_m.in_data[15*64 +: 64] = '1;
        drive(1, 15); tick();
        drive(0, 0);  tick();
        check("bnd_valid", 64'(bus_m.out_valid), 64'd1);
        check("bnd_data",  bus_m.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("bnd_sel",   64'(bus_m.out_sel), 64'd15);
        tick();

        // Parameter sweep: random traffic on 8x4 and 32x64, then a drain tail
        for (int c = 0; c < 300; c++) begin
            bit drain;
            int ss;
            int sb;
            drain = (c >= 280);
            bus_s.in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
            bus_s.in_sel    = 2'($urandom_range(0, 3));
            bus_s.in_data   = $urandom;
            bus_s.out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus_b.in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
            bus_b.in_sel    = 6'($urandom_range(0, 63));
            for (int w = 0; w < 64; w++) bus_b.in_data[w*32 +: 32] = $urandom;
            bus_b.out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            ss = int'(bus_s.in_sel);
            sb = int'(bus_b.in_sel);
            if (bus_s.in_valid && bus_s.in_ready) begin
                qs_data.push_back(bus_s.in_data[ss*8 +: 8]);
                qs_sel.push_back(bus_s.in_sel);
            end
            if (bus_b.in_valid && bus_b.in_ready) begin
                qb_data.push_back(bus_b.in_data[sb*32 +: 32]);
                qb_sel.push_back(bus_b.in_sel);
            end
            if (bus_s.out_valid && bus_s.out_ready) begin
                check("sw_s_expected", 64'(qs_data.size() != 0), 64'd1);
                if (qs_data.size() != 0) begin
                    check("sw_s_data", 64'(bus_s.out_data), 64'(qs_data.pop_front()));
                    check("sw_s_sel",  64'(bus_s.out_sel),  64'(qs_sel.pop_front()));
                end
            end
            if (bus_b.out_valid && bus_b.out_ready) begin
                check("sw_b_expected", 64'(qb_data.size() != 0), 64'd1);
                if (qb_data.size() != 0) begin
                    check("sw_b_data", 64'(bus_b.out_data), 64'(qb_data.pop_front()));
                    check("sw_b_sel",  64'(bus_b.out_sel),  64'(qb_sel.pop_front()));
                end
            end
            tick();
        end
        check("sw_s_lost", 64'(qs_data.size()), 64'd0);
        check("sw_b_lost", 64'(qb_data.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_pipe_tree.md
MUX_PIPE_TREE -- requirements
Module: mux_pipe_tree

Interface
REQ-001 Parameter WIDTH, default 64: data bits per input channel; legal range 1..64.
REQ-002 Parameter NUM_IN, default 16: input channel count; SHALL be a power of 4 with legal range 4..64.
REQ-003 Derived constant SELW = log2(NUM_IN); derived constant LEVELS = log4(NUM_IN), which is the number of 4:1 tree levels.
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge only.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1 bit: in_data and in_sel are valid this cycle.
REQ-007 Port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-008 Port in_data, input, NUM_IN*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port in_sel, input, SELW bits: binary index of the channel to forward.
REQ-010 Port out_valid, output, 1 bit: out_data and out_sel are valid.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the output this cycle.
REQ-012 Port out_data, output, WIDTH bits: the selected channel's data.
REQ-013 Port out_sel, output, SELW bits: in_sel as captured with the same transaction.

Function
REQ-014 The block SHALL be a LEVELS-stage pipelined 4:1 mux tree, with one register stage per level.
REQ-015 Level 0 SHALL be built from NUM_IN/4 muxes steered by in_sel[1:0].
REQ-016 Level j SHALL be steered by sel bits [2j+1:2j], taken from the select copy registered alongside that level.
REQ-017 Each stage SHALL register its partial results, its valid bit, and the full SELW-bit select.
REQ-018 Global advance signal: adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-019 When adv=1, every stage SHALL load from its predecessor, and stage 0 SHALL load in_valid, the level-0 results and in_sel.
REQ-020 When adv=0, every stage SHALL hold its data, select and valid unchanged.
REQ-021 A transaction is accepted when in_valid && in_ready; it SHALL appear on the output exactly LEVELS advancing cycles later.
- With out_ready held at 1, latency SHALL be LEVELS clocks.
REQ-022 out_data SHALL equal in_data[in_sel*WIDTH +: WIDTH] of the corresponding accepted transaction, bit-exact.
REQ-023 out_sel SHALL equal in_sel of that transaction.
REQ-024 Throughput SHALL be one transaction per clock while out_ready=1, with no bubbles inserted.
REQ-025 A cycle with in_valid=0 and adv=1 SHALL inject a bubble: the stage-0 valid bit loads 0, and the data registers may load don't-care values.
REQ-026 The stage data registers of bubbles SHALL NOT influence out_valid.
REQ-027 out_valid=1 with out_ready=0 SHALL hold out_data and out_sel stable until the handshake completes.
REQ-028 in_sel is always in range for a power-of-4 NUM_IN; no out-of-range handling is required.
REQ-029 Ordering SHALL be strictly FIFO: there is no reordering and no dropping.

Reset
REQ-030 While reset_n=0, all valid bits SHALL clear immediately, without waiting for a clock edge.
REQ-031 While reset_n=0, out_data, out_sel and all stage registers SHALL be 0.
REQ-032 After reset, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-033 Reset asserted mid-stream SHALL discard all in-flight transactions.
REQ-034 The first transaction accepted after reset_n rises SHALL emerge after LEVELS clocks.
REQ-035 Deassertion of reset_n SHALL be treated as synchronous to clk by the integrator; the block contains no internal synchroniser.

Verification
REQ-036 Bench SHALL cover these directed scenarios:
- Streaming. Config: WIDTH=64, NUM_IN=16, out_ready=1. Stimulus: channel k = 64'h1111_0000_0000_0000*k + k; in_sel = 0,5,10,15 on consecutive cycles. Response: out_data sequence equals channels 0,5,10,15, first valid 2 clocks after the first accept, then one result per clock.
- Backpressure. Stimulus: out_ready=0 for 3 cycles while in_valid=1. Response: in_ready=0 during the stall; out_data holds the same value; no transaction is lost or duplicated; the sequence resumes in order.
- Bubbles. Stimulus: in_valid pattern 1,0,1. Response: out_valid pattern 1,0,1 after 2 clocks; out_sel matches the accepted selects.
- Mid-stream reset. Stimulus: 2 transactions in flight, then reset_n pulsed low between clock edges. Response: out_valid=0 and out_data=0 immediately; nothing emerges afterwards until a new accept.
- Parameter sweep. Configs: WIDTH=8/NUM_IN=4 (latency 1) and WIDTH=32/NUM_IN=64 (latency 3). Stimulus: random in_sel with random out_ready. Response: every output matches the scoreboard.
- Boundary select. Stimulus: in_sel = NUM_IN-1 with channel value all-ones and all other channels 0. Response: out_data = all-ones and out_sel = NUM_IN-1.
